// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared constants and types for the MIPS execute-stage
//                multiplier: mfReg read-select encodings, multiplier FSM
//                state encoding and the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // Default operand width of the integer datapath
   localparam int DEF_WIDTH = 32;

   // mfReg read-select encodings (mflo / mfhi)
   localparam logic [1:0] MF_NONE = 2'b00;
   localparam logic [1:0] MF_LO   = 2'b01;
   localparam logic [1:0] MF_HI   = 2'b10;

   // Multiplier control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mult_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mult_datapath
//  Description : Shift-add datapath of the iterative multiplier. Holds the
//                magnitude operands, the 2*WIDTH accumulator and the sign
//                flag; presents the sign-corrected product combinationally.
//                Build option MULT_RADIX4_EN retires two multiplier bits per
//                step (WIDTH must then be even); otherwise one bit per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_datapath
   import mips_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,     // capture operands, clear accumulator
   input  logic                 step_i,     // perform one shift-add iteration
   input  logic                 signed_i,   // operands are two's complement
   input  logic [WIDTH-1:0]     a_i,        // multiplicand
   input  logic [WIDTH-1:0]     b_i,        // multiplier
   output logic [2*WIDTH-1:0]   product_o   // final signed/unsigned product
);

   localparam int PW = 2 * WIDTH;

`ifdef MULT_RADIX4_EN
   localparam int SHIFT = 2;
`else
   localparam int SHIFT = 1;
`endif

   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic             neg_q, neg_d;

   logic [WIDTH-1:0] w_a_abs;
   logic [WIDTH-1:0] w_b_abs;
   logic [PW-1:0]    w_pp;

   // Operand magnitudes; -(2^(WIDTH-1)) wraps to itself, read as unsigned 2^(WIDTH-1)
   always_comb begin
      w_a_abs = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      w_b_abs = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
   end

   // Partial product selected by the low multiplier bit(s)
   always_comb begin
      w_pp = '0;
`ifdef MULT_RADIX4_EN
      case (mplier_q[1:0])
         2'b01:   w_pp = mcand_q;
         2'b10:   w_pp = mcand_q << 1;
         2'b11:   w_pp = mcand_q + (mcand_q << 1);
         default: w_pp = '0;
      endcase
`else
      if (mplier_q[0]) begin
         w_pp = mcand_q;
      end
`endif
   end

   // Next-state: load operands on start, otherwise accumulate and shift per step
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      if (load_i) begin
         mcand_d  = {{WIDTH{1'b0}}, w_a_abs};
         mplier_d = w_b_abs;
         acc_d    = '0;
         neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      end else if (step_i) begin
         acc_d    = acc_q + w_pp;
         mcand_d  = mcand_q << SHIFT;
         mplier_d = mplier_q >> SHIFT;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
      end
   end

   // Sign correction of the magnitude product
   always_comb begin
      product_o = neg_q ? -acc_q : acc_q;
   end

endmodule : mult_datapath
`default_nettype wire

// File: rtl/mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_unit
//  Description : Iterative multi-cycle multiplier with architectural HI/LO
//                registers for the MIPS execute stage (mult / multu, mfhi /
//                mflo). multReady deasserts while a product is pending so the
//                hazard unit can stall fetch/decode.
//                Build option MULT_RADIX4_EN: two multiplier bits per cycle,
//                WIDTH/2 iterations. Results are identical in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             multStart,
   input  logic             multSigned,
   input  logic [WIDTH-1:0] srcAE,
   input  logic [WIDTH-1:0] srcBE,
   input  logic [1:0]       mfReg,
   output logic             multReady,
   output logic [WIDTH-1:0] mfOut,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

`ifdef MULT_RADIX4_EN
   localparam int ITERS = WIDTH / 2;
`else
   localparam int ITERS = WIDTH;
`endif

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mult_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    hi_q, hi_d;
   logic [WIDTH-1:0]    lo_q, lo_d;
   logic                ready_q, ready_d;

   logic                w_load;
   logic                w_step;
   logic [2*WIDTH-1:0]  w_product;

   // Datapath control: load only from IDLE, iterate until the counter reaches ITERS
   always_comb begin
      w_load = (state_q == IDLE) && multStart;
      w_step = (state_q == BUSY) && (cnt_q != LAST_CNT);
   end

   mult_datapath #(
      .WIDTH     (WIDTH)
   ) u_datapath (
      .clk       (clk),
      .reset     (reset),
      .load_i    (w_load),
      .step_i    (w_step),
      .signed_i  (multSigned),
      .a_i       (srcAE),
      .b_i       (srcBE),
      .product_o (w_product)
   );

   // FSM next-state, iteration counter and atomic HI/LO write in DONE.
   // multReady drops one edge after the start is accepted and rises on the
   // same edge that commits HI/LO.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ready_d = (state_q != BUSY);
      case (state_q)
         IDLE: begin
            if (multStart) begin
               state_d = BUSY;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DONE: begin
            {hi_d, lo_d} = w_product;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and architectural registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ready_q <= ready_d;
      end
   end

   // mfhi / mflo read mux from the registered HI/LO
   always_comb begin
      mfOut = '0;
      case (mfReg)
         MF_LO:   mfOut = lo_q;
         MF_HI:   mfOut = hi_q;
         default: mfOut = '0;
      endcase
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign multReady = ready_q;

endmodule : mult_unit
`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_unit
//  Description : Directed self-checking bench for mult_unit (default or
//                MULT_RADIX4_EN build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_unit;

`ifdef MULT_RADIX4_EN
   localparam int EXP_LOW = 17;
`else
   localparam int EXP_LOW = 33;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        multStart;
   logic        multSigned;
   logic [31:0] srcAE;
   logic [31:0] srcBE;
   logic [1:0]  mfReg;
   logic        multReady;
   logic [31:0] mfOut;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   int lowcnt;
   bit stable;

   always #5 clk = ~clk;

   mult_unit #(
      .WIDTH      (32),
      .CNT_W      (6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .multStart  (multStart),
      .multSigned (multSigned),
      .srcAE      (srcAE),
      .srcBE      (srcBE),
      .mfReg      (mfReg),
      .multReady  (multReady),
      .mfOut      (mfOut),
      .hi         (hi),
      .lo         (lo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one multiply, count cycles with multReady low and watch HI/LO stay put.
   // pulse_at > 0 raises a second multStart that many busy cycles in.
   task automatic run_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int pulse_at, output int low, output bit stab);
      logic [31:0] h0;
      logic [31:0] l0;
      @(negedge clk);
      multStart  = 1'b1;
      multSigned = s;
      srcAE      = a;
      srcBE      = b;
      @(negedge clk);
      multStart  = 1'b0;
      h0   = hi;
      l0   = lo;
      low  = 0;
      stab = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         multStart = 1'b0;
         if (multReady) break;
         low++;
         if (hi !== h0 || lo !== l0) stab = 1'b0;
         if (pulse_at != 0 && low == pulse_at) begin
            multStart  = 1'b1;
            multSigned = 1'b1;
            srcAE      = 32'd3;
            srcBE      = 32'd3;
         end
      end
      multStart = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      multStart  = 1'b0;
      multSigned = 1'b0;
      srcAE      = '0;
      srcBE      = '0;
      mfReg      = 2'b00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      mfReg = 2'b01;
      #1;
      chk("reset_ready", {31'd0, multReady}, 32'd1);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_mfout", mfOut, 32'd0);

      // Unsigned 7 x 6
      run_mult(1'b0, 32'd7, 32'd6, 0, lowcnt, stable);
      chk("u7x6_lowcnt", 32'(lowcnt), 32'(EXP_LOW));
      chk("u7x6_stable", {31'd0, stable}, 32'd1);
      chk("u7x6_lo", lo, 32'h0000_002A);
      chk("u7x6_hi", hi, 32'h0000_0000);
      mfReg = 2'b01; #1;
      chk("u7x6_mflo", mfOut, 32'h0000_002A);

      // Signed -3 x 5
      run_mult(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 0, lowcnt, stable);
      chk("sm3x5_lowcnt", 32'(lowcnt), 32'(EXP_LOW));
      chk("sm3x5_hi", hi, 32'hFFFF_FFFF);
      chk("sm3x5_lo", lo, 32'hFFFF_FFF1);
      mfReg = 2'b10; #1;
      chk("sm3x5_mfhi", mfOut, 32'hFFFF_FFFF);
      mfReg = 2'b11; #1;
      chk("mf_none11", mfOut, 32'h0000_0000);
      mfReg = 2'b00; #1;
      chk("mf_none00", mfOut, 32'h0000_0000);

      // Same bit pattern unsigned: (2^32-3)*5
      run_mult(1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 0, lowcnt, stable);
      chk("ufffd_x5_hi", hi, 32'h0000_0004);
      chk("ufffd_x5_lo", lo, 32'hFFFF_FFF1);

      // Signed -3 x -5 = 15
      run_mult(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 0, lowcnt, stable);
      chk("sm3xm5_hi", hi, 32'h0000_0000);
      chk("sm3xm5_lo", lo, 32'h0000_000F);

      // Unsigned max x max
      run_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lowcnt, stable);
      chk("umax_hi", hi, 32'hFFFF_FFFE);
      chk("umax_lo", lo, 32'h0000_0001);

      // Signed most-negative squared
      run_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 0, lowcnt, stable);
      chk("smin_hi", hi, 32'h4000_0000);
      chk("smin_lo", lo, 32'h0000_0000);

      // Second start 5 cycles into BUSY is ignored
      run_mult(1'b0, 32'h1234_5678, 32'h0000_0100, 5, lowcnt, stable);
      chk("ign_lowcnt", 32'(lowcnt), 32'(EXP_LOW));
      chk("ign_stable", {31'd0, stable}, 32'd1);
      chk("ign_hi", hi, 32'h0000_0012);
      chk("ign_lo", lo, 32'h3456_7800);

      // Reset 10 cycles into BUSY aborts the operation
      @(negedge clk);
      multStart  = 1'b1;
      multSigned = 1'b0;
      srcAE      = 32'h0000_FFFF;
      srcBE      = 32'h0000_FFFF;
      @(negedge clk);
      multStart = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_busy", {31'd0, multReady}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_ready", {31'd0, multReady}, 32'd1);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);

      // Fresh operation after the abort
      run_mult(1'b0, 32'd2, 32'd3, 0, lowcnt, stable);
      chk("post_lowcnt", 32'(lowcnt), 32'(EXP_LOW));
      chk("post_lo", lo, 32'd6);
      chk("post_hi", hi, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mult_unit
`default_nettype wire
